// File: rtl/elev_pkg.sv
// Shared types and default constants for the SCAN elevator controller.
// Imported by the selector and the controller top.
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int DEF_N_FLOORS = 8;
  localparam int DEF_MOVE_CYC = 4;
  localparam int DEF_DOOR_CYC = 3;

endpackage

// File: rtl/elev_prio_sel.sv
// Direction-aware target picker: nearest call ahead of the car,
// else nearest call behind; falls back to the car's own floor.
module elev_prio_sel
  import elev_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  localparam int FW = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] i_pending,
  input  logic [FW-1:0]       i_cur_floor,
  input  logic                i_dir_up,
  output logic [FW-1:0]       o_target,
  output logic                o_target_valid
);

  logic [31:0]   w_cur32;
  logic          w_up_hit;
  logic          w_dn_hit;
  logic [FW-1:0] w_up_idx;
  logic [FW-1:0] w_dn_idx;

  assign w_cur32 = 32'(i_cur_floor);

  always_comb begin
    w_up_hit = 1'b0;
    w_up_idx = i_cur_floor;
    w_dn_hit = 1'b0;
    w_dn_idx = i_cur_floor;
    // Up scan descends so the last hit is the lowest floor above.
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (i_pending[i] && (32'(i) > w_cur32)) begin
        w_up_hit = 1'b1;
        w_up_idx = FW'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i_pending[i] && (32'(i) < w_cur32)) begin
        w_dn_hit = 1'b1;
        w_dn_idx = FW'(i);
      end
    end
  end

  always_comb begin
    o_target = i_cur_floor;
    if (i_dir_up) begin
      if (w_up_hit)      o_target = w_up_idx;
      else if (w_dn_hit) o_target = w_dn_idx;
    end else begin
      if (w_dn_hit)      o_target = w_dn_idx;
      else if (w_up_hit) o_target = w_up_idx;
    end
  end

  assign o_target_valid = |i_pending;

endmodule

// File: rtl/elev_scan_ctrl.sv
// SCAN elevator controller: latches calls, sweeps in one direction
// serving calls en route, and reverses only when idle.
module elev_scan_ctrl
  import elev_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int MOVE_CYC = DEF_MOVE_CYC,
  parameter int DOOR_CYC = DEF_DOOR_CYC,
  localparam int FW = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  output logic [FW-1:0]       cur_floor,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic [FW-1:0]       target,
  output logic                target_valid
);

  localparam int MW = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  state_t              r_state;
  logic [FW-1:0]       r_cur;
  logic                r_dir;
  logic [N_FLOORS-1:0] r_pend;
  logic [MW-1:0]       r_mcnt;
  logic [DW-1:0]       r_dcnt;
  logic                r_moving;
  logic                r_door;

  state_t              w_nxt;
  logic [FW-1:0]       w_cur_nxt;
  logic                w_dir_nxt;
  logic [MW-1:0]       w_mcnt_nxt;
  logic [DW-1:0]       w_dcnt_nxt;
  logic [FW-1:0]       w_step;
  logic                w_edge;
  logic [N_FLOORS-1:0] w_clr;
  logic [FW-1:0]       w_tgt;
  logic                w_tv;

  elev_prio_sel #(
    .N_FLOORS(N_FLOORS)
  ) u_sel (
    .i_pending     (r_pend),
    .i_cur_floor   (r_cur),
    .i_dir_up      (r_dir),
    .o_target      (w_tgt),
    .o_target_valid(w_tv)
  );

  assign w_step = r_dir ? r_cur + 1'b1 : r_cur - 1'b1;
  assign w_edge = r_dir ? (r_cur == FW'(N_FLOORS - 1))
                        : (r_cur == '0);

  always_comb begin
    w_nxt      = r_state;
    w_cur_nxt  = r_cur;
    w_dir_nxt  = r_dir;
    w_mcnt_nxt = r_mcnt;
    w_dcnt_nxt = r_dcnt;
    unique case (r_state)
      IDLE: begin
        if (r_pend[r_cur]) begin
          w_nxt = DOOR;
        end else if (w_tv) begin
          w_nxt      = MOVE;
          w_dir_nxt  = (w_tgt > r_cur);
          w_mcnt_nxt = '0;
        end
      end
      MOVE: begin
        if (r_mcnt == MW'(MOVE_CYC - 1)) begin
          w_mcnt_nxt = '0;
          if (w_edge) begin
            w_nxt = IDLE;
          end else begin
            w_cur_nxt = w_step;
            if (r_pend[w_step]) w_nxt = DOOR;
          end
        end else begin
          w_mcnt_nxt = r_mcnt + 1'b1;
        end
      end
      DOOR: begin
        if (r_dcnt == DW'(DOOR_CYC - 1)) begin
          w_dcnt_nxt = '0;
          w_nxt      = IDLE;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Clearing the car's floor during DOOR wins over a same-cycle call.
  assign w_clr = (r_state == DOOR) ? (N_FLOORS'(1) << r_cur) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cur    <= '0;
      r_dir    <= 1'b1;
      r_pend   <= '0;
      r_mcnt   <= '0;
      r_dcnt   <= '0;
      r_moving <= 1'b0;
      r_door   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cur    <= w_cur_nxt;
      r_dir    <= w_dir_nxt;
      r_pend   <= (r_pend | req) & ~w_clr;
      r_mcnt   <= w_mcnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_moving <= (w_nxt == MOVE);
      r_door   <= (w_nxt == DOOR);
    end
  end

  assign cur_floor    = r_cur;
  assign dir_up       = r_dir;
  assign moving       = r_moving;
  assign door_open    = r_door;
  assign pending      = r_pend;
  assign target       = w_tgt;
  assign target_valid = w_tv;

endmodule

// File: tb/tb_elev_scan_ctrl.sv
// Directed scenario bench for elev_scan_ctrl (8 floors, 4/3 cycles).
// Each task drives one scenario and checks against hand-computed values.
module tb_elev_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [7:0] pending;
  logic [2:0] target;
  logic       target_valid;

  int n_chk;
  int n_fail;

  elev_scan_ctrl #(
    .N_FLOORS(8),
    .MOVE_CYC(4),
    .DOOR_CYC(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .moving      (moving),
    .door_open   (door_open),
    .pending     (pending),
    .target      (target),
    .target_valid(target_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic run_to_door(output int mv);
    mv = 0;
    while (!door_open && mv < 200) begin
      if (moving) mv++;
      tick();
    end
  endtask

  task automatic door_wait(output int dc);
    dc = 0;
    while (door_open && dc < 50) begin
      dc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({cur_floor, dir_up, moving, door_open} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_ctrl got cur=%0d dir=%b mv=%b door=%b want 0 1 0 0",
               cur_floor, dir_up, moving, door_open);
    end
    n_chk++;
    if ({pending, target_valid, target} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_sel got pend=%h tv=%b tgt=%0d want 00 0 0",
               pending, target_valid, target);
    end
  endtask

  task automatic test_single();
    int mv, dc;
    do_reset();
    pulse_req(8'b0010_0000);
    n_chk++;
    if ({pending, target_valid, target, moving} !== {8'h20, 1'b1, 3'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL single_latch got pend=%h tv=%b tgt=%0d mv=%b want 20 1 5 0",
               pending, target_valid, target, moving);
    end
    tick();
    n_chk++;
    if ({moving, dir_up} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_start got mv=%b dir=%b want 1 1", moving, dir_up);
    end
    run_to_door(mv);
    n_chk++;
    if (mv !== 20 || cur_floor !== 3'd5) begin
      n_fail++;
      $display("FAIL single_travel got cyc=%0d cur=%0d want 20 5", mv, cur_floor);
    end
    door_wait(dc);
    n_chk++;
    if (dc !== 3) begin
      n_fail++;
      $display("FAIL single_door got %0d want 3", dc);
    end
    n_chk++;
    if ({pending, moving, door_open, target_valid} !== 11'h000) begin
      n_fail++;
      $display("FAIL single_idle got pend=%h mv=%b door=%b tv=%b want 00 0 0 0",
               pending, moving, door_open, target_valid);
    end
  endtask

  task automatic test_en_route();
    int mv, dc;
    do_reset();
    pulse_req(8'b0100_1000);
    n_chk++;
    if (target !== 3'd3) begin
      n_fail++;
      $display("FAIL route_target got %0d want 3", target);
    end
    run_to_door(mv);
    n_chk++;
    if (mv !== 12 || cur_floor !== 3'd3 || dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL route_stop3 got cyc=%0d cur=%0d dir=%b want 12 3 1",
               mv, cur_floor, dir_up);
    end
    door_wait(dc);
    n_chk++;
    if (dc !== 3 || pending !== 8'h40 || dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL route_after3 got dc=%0d pend=%h dir=%b want 3 40 1",
               dc, pending, dir_up);
    end
    run_to_door(mv);
    n_chk++;
    if (mv !== 12 || cur_floor !== 3'd6 || dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL route_stop6 got cyc=%0d cur=%0d dir=%b want 12 6 1",
               mv, cur_floor, dir_up);
    end
    door_wait(dc);
    n_chk++;
    if (dc !== 3 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL route_done got dc=%0d pend=%h want 3 00", dc, pending);
    end
  endtask

  task automatic test_reverse();
    int mv, dc;
    do_reset();
    pulse_req(8'b0010_0000);
    run_to_door(mv);
    door_wait(dc);
    pulse_req(8'b1000_0010);
    n_chk++;
    if (target !== 3'd7 || dir_up !== 1'b1 || cur_floor !== 3'd5) begin
      n_fail++;
      $display("FAIL rev_pick got tgt=%0d dir=%b cur=%0d want 7 1 5",
               target, dir_up, cur_floor);
    end
    run_to_door(mv);
    n_chk++;
    if (mv !== 8 || cur_floor !== 3'd7) begin
      n_fail++;
      $display("FAIL rev_up got cyc=%0d cur=%0d want 8 7", mv, cur_floor);
    end
    door_wait(dc);
    n_chk++;
    if (dir_up !== 1'b1 || target !== 3'd1 || pending !== 8'h02) begin
      n_fail++;
      $display("FAIL rev_idle got dir=%b tgt=%0d pend=%h want 1 1 02",
               dir_up, target, pending);
    end
    tick();
    n_chk++;
    if ({moving, dir_up} !== 2'b10) begin
      n_fail++;
      $display("FAIL rev_turn got mv=%b dir=%b want 1 0", moving, dir_up);
    end
    run_to_door(mv);
    n_chk++;
    if (mv !== 24 || cur_floor !== 3'd1) begin
      n_fail++;
      $display("FAIL rev_down got cyc=%0d cur=%0d want 24 1", mv, cur_floor);
    end
    door_wait(dc);
    n_chk++;
    if (pending !== 8'h00) begin
      n_fail++;
      $display("FAIL rev_done got pend=%h want 00", pending);
    end
  endtask

  task automatic test_door_absorb();
    int dc;
    pulse_req(8'h02);
    tick();
    n_chk++;
    if ({door_open, moving, cur_floor} !== {1'b1, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL absorb_open got door=%b mv=%b cur=%0d want 1 0 1",
               door_open, moving, cur_floor);
    end
    req = 8'h12;
    tick();
    req = '0;
    n_chk++;
    if (pending !== 8'h10) begin
      n_fail++;
      $display("FAIL absorb_pend got %h want 10", pending);
    end
    door_wait(dc);
    n_chk++;
    if (dc !== 2 || pending !== 8'h10 || cur_floor !== 3'd1) begin
      n_fail++;
      $display("FAIL absorb_exit got dc=%0d pend=%h cur=%0d want 2 10 1",
               dc, pending, cur_floor);
    end
  endtask

  task automatic test_same_floor();
    int mv, dc;
    do_reset();
    pulse_req(8'h04);
    run_to_door(mv);
    door_wait(dc);
    pulse_req(8'h04);
    n_chk++;
    if ({pending, moving, door_open} !== {8'h04, 2'b00}) begin
      n_fail++;
      $display("FAIL same_latch got pend=%h mv=%b door=%b want 04 0 0",
               pending, moving, door_open);
    end
    tick();
    n_chk++;
    if ({door_open, moving, cur_floor} !== {1'b1, 1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL same_door got door=%b mv=%b cur=%0d want 1 0 2",
               door_open, moving, cur_floor);
    end
    door_wait(dc);
    n_chk++;
    if (dc !== 3 || pending !== 8'h00 || cur_floor !== 3'd2 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL same_exit got dc=%0d pend=%h cur=%0d mv=%b want 3 00 2 0",
               dc, pending, cur_floor, moving);
    end
  endtask

  task automatic test_reset_mid_move();
    pulse_req(8'hF0);
    tick();
    tick();
    n_chk++;
    if (pending !== 8'hF0 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL rmm_pre got pend=%h mv=%b want f0 1", pending, moving);
    end
    rst = 1'b1;
    req = 8'hFF;
    tick();
    n_chk++;
    if ({cur_floor, dir_up, moving, door_open, pending, target_valid, target}
        !== {3'd0, 1'b1, 2'b00, 8'h00, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL rmm_rst got cur=%0d dir=%b mv=%b door=%b pend=%h tv=%b tgt=%0d want 0 1 0 0 00 0 0",
               cur_floor, dir_up, moving, door_open, pending, target_valid, target);
    end
    rst = 1'b0;
    req = '0;
    tick();
    n_chk++;
    if (pending !== 8'h00 || moving !== 1'b0 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL rmm_post got pend=%h mv=%b door=%b want 00 0 0",
               pending, moving, door_open);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req    = '0;
    test_reset();
    test_single();
    test_en_route();
    test_reverse();
    test_door_absorb();
    test_same_floor();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/elev_scan_ctrl.md
ELEV_SCAN_CTRL -- requirements
Module: elev_scan_ctrl

Interface
REQ-001 SHALL have parameter N_FLOORS, default 8, number of served floors (2..32).
REQ-002 SHALL have parameter MOVE_CYC, default 4, clock cycles to travel one floor (>=1).
REQ-003 SHALL have parameter DOOR_CYC, default 3, clock cycles the door stays open (>=1).
REQ-004 SHALL derive localparam FW = $clog2(N_FLOORS), floor index width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req  input  N_FLOORS  floor call buttons, one bit per floor, level or pulse.
REQ-008 cur_floor  output  FW  floor the car is at or last passed.
REQ-009 dir_up  output  1  1 = current sweep direction up, 0 = down.
REQ-010 moving  output  1  high while the state is MOVE.
REQ-011 door_open  output  1  high while the state is DOOR.
REQ-012 pending  output  N_FLOORS  latched unserved requests.
REQ-013 target  output  FW  floor chosen by the direction-aware priority selector; valid only when target_valid is high.
REQ-014 target_valid  output  1  high when pending is non-zero.

Function
REQ-015 Each pending bit SHALL be set the cycle after req bit is sampled high and held until served; it reads back one cycle after the request.
REQ-016 Selector, combinational from pending, cur_floor, dir_up: dir_up=1 picks lowest pending floor > cur_floor, else highest pending floor < cur_floor; dir_up=0 picks the mirror; target_valid=0 and target=cur_floor when pending is zero.
REQ-017 FSM states: IDLE, MOVE, DOOR.
REQ-018 IDLE: pending[cur_floor]=1 -> DOOR; else target_valid=1 -> MOVE, dir_up set to (target > cur_floor) in the same cycle; else stay IDLE.
REQ-019 MOVE: cycle counter counts 0..MOVE_CYC-1; on the cycle it reaches MOVE_CYC-1, cur_floor steps +1 (dir_up) or -1 and counter clears.
REQ-020 MOVE: after a step, if pending[new floor]=1 -> DOOR (intermediate calls served en route); else stay MOVE toward target.
REQ-021 cur_floor SHALL never step past 0 or N_FLOORS-1; a step that would do so is suppressed and the FSM returns to IDLE.
REQ-022 DOOR: door_open=1 for exactly DOOR_CYC cycles, then IDLE; pending[cur_floor] cleared every DOOR cycle.
REQ-023 A req for cur_floor arriving while in DOOR SHALL be absorbed (clear beats set); requests for other floors latch normally.
REQ-024 Sweep reversal: dir_up changes only in IDLE, and only when no pending floor lies in the current direction.
REQ-025 req bits >= N_FLOORS do not exist; all outputs are registered except target and target_valid.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, cur_floor=0, dir_up=1, pending=0, counters=0, moving=0, door_open=0.
REQ-027 Reset mid-MOVE or mid-DOOR SHALL abandon the operation with no residual pending bits; rst overrides req in the same cycle.

Structure
REQ-028 Package elev_pkg SHALL hold the state enum (IDLE, MOVE, DOOR) and default parameter constants.
REQ-029 Sub-module elev_prio_sel SHALL implement REQ-016, parametrised by N_FLOORS, purely combinational.

Verification (N_FLOORS=8, MOVE_CYC=4, DOOR_CYC=3)
REQ-030 Reset, then req=8'b0010_0000 one cycle -> pending bit 5 next cycle, MOVE up, cur_floor 5 after 20 MOVE cycles, door_open 3 cycles, pending=0, IDLE.
REQ-031 At floor 0, req floors 6 and 3 together -> stop at 3 (door), then 6; dir_up stays 1 throughout.
REQ-032 At floor 5 dir_up=1, pending floors 1 and 7 -> serve 7 first, reverse in IDLE, then serve 1.
REQ-033 req for cur_floor during DOOR -> pending bit stays 0, DOOR still exits after 3 cycles.
REQ-034 req while IDLE at cur_floor=2 for floor 2 -> DOOR with no MOVE, cur_floor unchanged.
REQ-035 rst asserted mid-MOVE with pending=8'hF0 -> next cycle all outputs at reset values, pending=0.
